// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of a single-port data memory: one transaction at a time,
// one memory cycle per grant, registered ack/rdata, round-robin or fixed port-0 priority.
module dmem_port_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int FIXED_PRI = 0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             m0_req,
    input  logic             m0_we,
    input  logic [AW-1:0]    m0_addr,
    input  logic [DW-1:0]    m0_wdata,
    output logic             m0_ack,
    output logic [DW-1:0]    m0_rdata,
    input  logic             m1_req,
    input  logic             m1_we,
    input  logic [AW-1:0]    m1_addr,
    input  logic [DW-1:0]    m1_wdata,
    output logic             m1_ack,
    output logic [DW-1:0]    m1_rdata,
    output logic [AW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_wdata,
    output logic             mem_we,
    input  logic [DW-1:0]    mem_rdata,
    output logic             busy,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        state, state_nxt;
    logic          owner;
    logic          last_served;
    logic          grant_valid;
    logic          grant;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;

    // On a tie the port that was not served last wins, unless port 0 is hard-prioritised.
    always_comb begin
        grant_valid = m0_req | m1_req;
        if (m0_req && m1_req)
            grant = (FIXED_PRI != 0) ? 1'b0 : ~last_served;
        else
            grant = m1_req;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_valid) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_we = (state == ACCESS) && lat_we;
        m0_ack = (state == RESP) && !owner;
        m1_ack = (state == RESP) && owner;
        busy   = (state != IDLE);
    end

    // Latched request doubles as the memory-side address/data, so they hold between accesses.
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner       <= 1'b0;
            last_served <= 1'b1;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            m0_rdata    <= '0;
            m1_rdata    <= '0;
            cnt0        <= '0;
            cnt1        <= '0;
        end else begin
            if (state == IDLE && grant_valid) begin
                owner     <= grant;
                lat_we    <= grant ? m1_we    : m0_we;
                lat_addr  <= grant ? m1_addr  : m0_addr;
                lat_wdata <= grant ? m1_wdata : m0_wdata;
            end
            if (state == ACCESS) begin
                last_served <= owner;
                if (owner) begin
                    cnt1 <= cnt1 + 1'b1;
                    if (!lat_we) m1_rdata <= mem_rdata;
                end else begin
                    cnt0 <= cnt0 + 1'b1;
                    if (!lat_we) m0_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: a round-robin instance (4-bit counters) and a fixed-priority
// instance share request inputs; each has its own behavioural memory.
module tb_dmem_port_arbiter;
    localparam int CW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        init_mem = 1'b0;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;

    logic          r_m0_ack, r_m1_ack, r_mem_we, r_busy;
    logic [31:0]   r_m0_rdata, r_m1_rdata, r_mem_addr, r_mem_wdata, r_mem_rdata;
    logic [CW-1:0] r_cnt0, r_cnt1;
    logic          f_m0_ack, f_m1_ack, f_mem_we, f_busy;
    logic [31:0]   f_m0_rdata, f_m1_rdata, f_mem_addr, f_mem_wdata, f_mem_rdata;
    logic [15:0]   f_cnt0, f_cnt1;

    logic [31:0] r_mem [256];
    logic [31:0] f_mem [256];
    logic [31:0] model [256];
    int          r_we_cycles = 0;
    int          checks = 0, errors = 0;

    logic        sel_fp = 1'b0;
    logic        s_ack0, s_ack1, s_we;
    logic [31:0] s_rd0, s_rd1, s_addr, s_wdata;
    logic [15:0] s_cnt0, s_cnt1;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.AW(32), .DW(32), .FIXED_PRI(0), .CNT_W(CW)) u_rr (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(r_m0_ack), .m0_rdata(r_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(r_m1_ack), .m1_rdata(r_m1_rdata),
        .mem_addr(r_mem_addr), .mem_wdata(r_mem_wdata), .mem_we(r_mem_we),
        .mem_rdata(r_mem_rdata), .busy(r_busy), .cnt0(r_cnt0), .cnt1(r_cnt1));

    dmem_port_arbiter #(.AW(32), .DW(32), .FIXED_PRI(1), .CNT_W(16)) u_fp (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(f_m0_ack), .m0_rdata(f_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(f_m1_ack), .m1_rdata(f_m1_rdata),
        .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata), .mem_we(f_mem_we),
        .mem_rdata(f_mem_rdata), .busy(f_busy), .cnt0(f_cnt0), .cnt1(f_cnt1));

    assign r_mem_rdata = r_mem[r_mem_addr[9:2]];
    assign f_mem_rdata = f_mem[f_mem_addr[9:2]];

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) begin
                r_mem[i] <= 32'(i * 3 + 1);
                f_mem[i] <= 32'(i * 3 + 1);
            end
        end else begin
            if (r_mem_we) r_mem[r_mem_addr[9:2]] <= r_mem_wdata;
            if (f_mem_we) f_mem[f_mem_addr[9:2]] <= f_mem_wdata;
        end
    end

    always @(posedge clk) if (r_mem_we) r_we_cycles++;

    assign s_ack0  = sel_fp ? f_m0_ack    : r_m0_ack;
    assign s_ack1  = sel_fp ? f_m1_ack    : r_m1_ack;
    assign s_we    = sel_fp ? f_mem_we    : r_mem_we;
    assign s_rd0   = sel_fp ? f_m0_rdata  : r_m0_rdata;
    assign s_rd1   = sel_fp ? f_m1_rdata  : r_m1_rdata;
    assign s_addr  = sel_fp ? f_mem_addr  : r_mem_addr;
    assign s_wdata = sel_fp ? f_mem_wdata : r_mem_wdata;
    assign s_cnt0  = sel_fp ? f_cnt0 : {12'd0, r_cnt0};
    assign s_cnt1  = sel_fp ? f_cnt1 : {12'd0, r_cnt1};

    task automatic do_reset();
        rst = 1'b0;
        m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
        init_mem = 1'b1;
        @(negedge clk);
        init_mem = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 256; i++) model[i] = 32'(i * 3 + 1);
    endtask

    // One transaction on the selected instance; returns with the arbiter back in IDLE.
    task automatic xact(input bit p, input bit we, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output bit ok);
        ok = 1'b0;
        rd = '0;
        if (!p) begin m0_req = 1; m0_we = we; m0_addr = a; m0_wdata = d; end
        else    begin m1_req = 1; m1_we = we; m1_addr = a; m1_wdata = d; end
        for (int i = 0; i < 8 && !ok; i++) begin
            @(negedge clk);
            if (p ? s_ack1 : s_ack0) begin ok = 1'b1; rd = p ? s_rd1 : s_rd0; end
        end
        m0_req = 0; m1_req = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({r_mem_we, r_m0_ack, r_m1_ack, r_busy, f_mem_we, f_m0_ack, f_m1_ack, f_busy} !== 8'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b want 00000000",
                {r_mem_we, r_m0_ack, r_m1_ack, r_busy, f_mem_we, f_m0_ack, f_m1_ack, f_busy});
        end
        checks++;
        if ({r_m0_rdata, r_m1_rdata, r_mem_addr, r_mem_wdata, r_cnt0, r_cnt1, f_cnt0, f_cnt1} !== '0) begin
            errors++; $display("FAIL reset_data: rd0=%h rd1=%h addr=%h wdata=%h c0=%0d c1=%0d want all 0",
                r_m0_rdata, r_m1_rdata, r_mem_addr, r_mem_wdata, r_cnt0, r_cnt1);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        int w0;
        sel_fp = 0;
        w0 = r_we_cycles;
        m0_req = 1; m0_we = 1; m0_addr = 32'h100; m0_wdata = 32'd4;
        @(negedge clk);
        checks++;
        if (r_mem_we !== 1'b1 || r_mem_addr !== 32'h100 || r_mem_wdata !== 32'd4 || r_m0_ack !== 1'b0) begin
            errors++; $display("FAIL t1_access: we=%b addr=%h data=%h ack=%b want 1 100 4 0",
                r_mem_we, r_mem_addr, r_mem_wdata, r_m0_ack);
        end
        @(negedge clk);
        checks++;
        if (r_m0_ack !== 1'b1 || r_m1_ack !== 1'b0 || r_mem_we !== 1'b0 || r_cnt0 !== 4'd1 || r_busy !== 1'b1) begin
            errors++; $display("FAIL t1_ack: ack0=%b ack1=%b we=%b cnt0=%0d busy=%b want 1 0 0 1 1",
                r_m0_ack, r_m1_ack, r_mem_we, r_cnt0, r_busy);
        end
        m0_req = 0;
        @(negedge clk);
        checks++;
        if (r_m0_ack !== 1'b0 || r_busy !== 1'b0 || r_we_cycles != w0 + 1 || r_mem[64] !== 32'd4) begin
            errors++; $display("FAIL t1_after: ack0=%b busy=%b we_cycles=%0d mem64=%h want 0 0 %0d 4",
                r_m0_ack, r_busy, r_we_cycles - w0, r_mem[64], 1);
        end
        // Address/data outputs keep their last driven values once idle.
        checks++;
        if (r_mem_addr !== 32'h100 || r_mem_wdata !== 32'd4) begin
            errors++; $display("FAIL t1_hold: addr=%h data=%h want 100 4", r_mem_addr, r_mem_wdata);
        end
    endtask

    task automatic test_read();
        logic [31:0] rd;
        bit          ok;
        int          w0;
        sel_fp = 0;
        w0 = r_we_cycles;
        xact(1'b1, 1'b0, 32'h100, 32'h0, rd, ok);
        checks++;
        if (!ok || rd !== 32'd4 || r_cnt1 !== 4'd1 || r_we_cycles != w0) begin
            errors++; $display("FAIL t2_read: ok=%b rdata=%h cnt1=%0d writes=%0d want 1 4 1 0",
                ok, rd, r_cnt1, r_we_cycles - w0);
        end
        checks++;
        if (r_m1_rdata !== 32'd4 || r_m0_rdata !== 32'd0) begin
            errors++; $display("FAIL t2_hold: rd1=%h rd0=%h want 4 0", r_m1_rdata, r_m0_rdata);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp;
        sel_fp = 0;
        do_reset();
        m0_req = 1; m0_we = 0; m0_addr = 32'h10;
        m1_req = 1; m1_we = 0; m1_addr = 32'h20;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            exp = 2'b00;
            if (i >= 2 && (i - 2) % 3 == 0) exp = (((i - 2) / 3) % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if ({r_m1_ack, r_m0_ack} !== exp) begin
                errors++; $display("FAIL t3_rr cycle %0d: acks(m1,m0)=%b want %b", i, {r_m1_ack, r_m0_ack}, exp);
            end
            if (i == 11) begin m0_req = 0; m1_req = 0; end
        end
        checks++;
        if (r_cnt0 !== 4'd2 || r_cnt1 !== 4'd2 || r_m0_rdata !== model[4] || r_m1_rdata !== model[8]) begin
            errors++; $display("FAIL t3_end: cnt0=%0d cnt1=%0d rd0=%h rd1=%h want 2 2 %h %h",
                r_cnt0, r_cnt1, r_m0_rdata, r_m1_rdata, model[4], model[8]);
        end
    endtask

    task automatic test_fixed_pri();
        sel_fp = 1;
        do_reset();
        m0_req = 1; m0_we = 1; m0_addr = 32'h40; m0_wdata = 32'hA5;
        m1_req = 1; m1_we = 1; m1_addr = 32'h44; m1_wdata = 32'h5A;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            checks++;
            if ({f_m1_ack, f_m0_ack} !== ((i % 3 == 2) ? 2'b01 : 2'b00)) begin
                errors++; $display("FAIL t4_fixed cycle %0d: acks(m1,m0)=%b want %b",
                    i, {f_m1_ack, f_m0_ack}, (i % 3 == 2) ? 2'b01 : 2'b00);
            end
        end
        m0_req = 0; m1_req = 0;
        @(negedge clk);
        checks++;
        if (f_cnt0 !== 16'd3 || f_cnt1 !== 16'd0 || f_mem[17] !== model[17]) begin
            errors++; $display("FAIL t4_end: cnt0=%0d cnt1=%0d mem17=%h want 3 0 %h", f_cnt0, f_cnt1, f_mem[17], model[17]);
        end
        sel_fp = 0;
    endtask

    task automatic test_reset_mid();
        sel_fp = 0;
        do_reset();
        m1_req = 1; m1_we = 1; m1_addr = 32'h104; m1_wdata = 32'hDEAD;
        @(negedge clk);
        checks++;
        if (r_mem_we !== 1'b1 || r_mem_addr !== 32'h104) begin
            errors++; $display("FAIL t5_access: we=%b addr=%h want 1 104", r_mem_we, r_mem_addr);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (r_mem_we !== 1'b0 || r_busy !== 1'b0 || r_m1_ack !== 1'b0) begin
            errors++; $display("FAIL t5_async: we=%b busy=%b ack1=%b want 0 0 0", r_mem_we, r_busy, r_m1_ack);
        end
        m1_req = 0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (r_m1_ack !== 1'b0 || r_cnt1 !== 4'd0 || r_mem[65] !== model[65]) begin
                errors++; $display("FAIL t5_after: ack1=%b cnt1=%0d mem65=%h want 0 0 %h", r_m1_ack, r_cnt1, r_mem[65], model[65]);
            end
        end
    endtask

    task automatic test_wrap_sort();
        logic [31:0] rd, a, b;
        bit          ok, all_ok;
        int          vals [5] = '{4, 5, 3, 1, 2};
        sel_fp = 0;
        do_reset();
        all_ok = 1;
        for (int i = 0; i < 16; i++) begin
            xact(1'b0, 1'b1, 32'(i * 4), 32'(i), rd, ok);
            all_ok &= ok;
            if (i == 14) begin
                checks++;
                if (r_cnt0 !== 4'd15) begin errors++; $display("FAIL t6_cnt15: got %0d want 15", r_cnt0); end
            end
        end
        checks++;
        if (!all_ok || r_cnt0 !== 4'd0) begin
            errors++; $display("FAIL t6_wrap: ok=%b cnt0=%0d want 1 0", all_ok, r_cnt0);
        end
        for (int i = 0; i < 5; i++) begin xact(1'b1, 1'b1, 32'h200 + 32'(i * 4), 32'(vals[i]), rd, ok); all_ok &= ok; end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4 - i; j++) begin
                xact(1'b0, 1'b0, 32'h200 + 32'(j * 4), 32'h0, a, ok); all_ok &= ok;
                xact(1'b0, 1'b0, 32'h204 + 32'(j * 4), 32'h0, b, ok); all_ok &= ok;
                if (a > b) begin
                    xact(1'b0, 1'b1, 32'h200 + 32'(j * 4), b, rd, ok); all_ok &= ok;
                    xact(1'b0, 1'b1, 32'h204 + 32'(j * 4), a, rd, ok); all_ok &= ok;
                end
            end
        for (int i = 0; i < 5; i++) begin
            xact(1'b1, 1'b0, 32'h200 + 32'(i * 4), 32'h0, rd, ok);
            checks++;
            if (!ok || !all_ok || rd !== 32'(i + 1)) begin
                errors++; $display("FAIL t6_sort[%0d]: ok=%b got %0d want %0d", i, ok && all_ok, rd, i + 1);
            end
        end
    endtask

    // Random two-port traffic checked against a transaction-level model of the arbiter.
    task automatic test_random(input bit fp, input int n);
        bit          p0 = 0, p1 = 0, last = 1, w, we;
        logic [31:0] a0 = '0, a1 = '0, d0 = '0, d1 = '0, a, d, exp;
        bit          we0 = 0, we1 = 0;
        int          c0 = 0, c1 = 0, mask;
        sel_fp = fp;
        do_reset();
        mask = fp ? 32'hFFFF : (1 << CW) - 1;
        for (int k = 0; k < n; k++) begin
            if (!p0 && $urandom_range(0, 2) != 0) begin
                p0 = 1; we0 = 1'($urandom_range(0, 1)); a0 = {22'd0, 8'($urandom_range(0, 255)), 2'b00}; d0 = $urandom;
            end
            if (!p1 && $urandom_range(0, 2) != 0) begin
                p1 = 1; we1 = 1'($urandom_range(0, 1)); a1 = {22'd0, 8'($urandom_range(0, 255)), 2'b00}; d1 = $urandom;
            end
            m0_req = p0; m0_we = we0; m0_addr = a0; m0_wdata = d0;
            m1_req = p1; m1_we = we1; m1_addr = a1; m1_wdata = d1;
            if (!p0 && !p1) begin @(negedge clk); continue; end
            if (p0 && p1) w = fp ? 1'b0 : (last == 1'b0);
            else          w = p1;
            we = w ? we1 : we0;
            a  = w ? a1 : a0;
            d  = w ? d1 : d0;
            @(negedge clk);
            checks++;
            if (s_we !== we || s_addr !== a || (we && s_wdata !== d)) begin
                errors++; $display("FAIL rnd%0d_access #%0d: we=%b addr=%h data=%h want %b %h %h", fp, k, s_we, s_addr, s_wdata, we, a, d);
            end
            @(negedge clk);
            checks++;
            if ({s_ack1, s_ack0} !== (w ? 2'b10 : 2'b01) || s_we !== 1'b0) begin
                errors++; $display("FAIL rnd%0d_ack #%0d: acks(m1,m0)=%b we=%b want %b 0", fp, k, {s_ack1, s_ack0}, s_we, w ? 2'b10 : 2'b01);
            end
            if (w) c1++; else c0++;
            if (!we) begin
                exp = model[a[9:2]];
                checks++;
                if ((w ? s_rd1 : s_rd0) !== exp) begin
                    errors++; $display("FAIL rnd%0d_rdata #%0d: got %h want %h", fp, k, w ? s_rd1 : s_rd0, exp);
                end
            end else model[a[9:2]] = d;
            checks++;
            if (s_cnt0 !== 16'(c0 & mask) || s_cnt1 !== 16'(c1 & mask)) begin
                errors++; $display("FAIL rnd%0d_cnt #%0d: cnt0=%0d cnt1=%0d want %0d %0d", fp, k, s_cnt0, s_cnt1, c0 & mask, c1 & mask);
            end
            last = w;
            if (w) begin p1 = 0; m1_req = 0; end
            else   begin p0 = 0; m0_req = 0; end
            @(negedge clk);
        end
        m0_req = 0; m1_req = 0;
        @(negedge clk);
        sel_fp = 0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_fixed_pri();
        test_reset_mid();
        test_wrap_sort();
        test_random(1'b0, 300);
        test_random(1'b1, 200);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

endmodule
